// File: rtl/controle_multiciclo.sv
// Control FSM for the multi-cycle RISC-V datapath: sequences FETCH..WB/BRANCH,
// keeps the word-indexed pc and drives registered per-state datapath strobes.
module controle_multiciclo #(
    parameter int unsigned N_INSTR   = 9,
    parameter int unsigned PC_INICIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        executar,
    input  logic [31:0] instrucao,
    input  logic        zero,
    output logic [3:0]  estado,
    output logic [31:0] pc,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        alu_src,
    output logic        halted,
    output logic        erro
);

    localparam int unsigned PC_W  = 32;
    localparam int unsigned OP_W  = 7;
    localparam int unsigned F3_W  = 3;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'b0000,
        S_DECODE = 4'b0001,
        S_EXEC   = 4'b0010,
        S_MEM    = 4'b0011,
        S_WB     = 4'b0100,
        S_BRANCH = 4'b0101,
        S_ERRO   = 4'b1110,
        S_HALT   = 4'b1111
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, pc_next;
    logic [OP_W-1:0]   opcode_q, opcode_d;
    logic [F3_W-1:0]   funct3_q, funct3_d;
    logic [PC_W-1:0]   imm_q, imm_d;
    logic              reg_write_d, mem_read_d, mem_write_d, alu_src_d;
    logic              halted_d, erro_d;
    logic              taken, fim_instr;
    logic              unused_instr_bits;

    // Register-operand fields are consumed by the datapath, not by control.
    assign unused_instr_bits = ^instrucao[24:15];

    // Next state, pc and latched instruction fields.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        funct3_d  = funct3_q;
        imm_d     = imm_q;
        fim_instr = 1'b0;

        taken   = ((funct3_q == 3'b000) && zero) || ((funct3_q == 3'b001) && !zero);
        // B-immediate is a byte offset; the arithmetic shift turns it into words.
        pc_next = (state_q == S_BRANCH && taken)
                ? pc_q + PC_W'($signed(imm_q) >>> 2)
                : pc_q + PC_W'(1);

        if (executar) begin
            case (state_q)
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: begin
                    opcode_d = instrucao[6:0];
                    funct3_d = instrucao[14:12];
                    imm_d    = {{19{instrucao[31]}}, instrucao[31], instrucao[7],
                                instrucao[30:25], instrucao[11:8], 1'b0};
                    if (instrucao == 32'h0) begin
                        state_d = S_HALT;
                    end else begin
                        case (instrucao[6:0])
                            OP_LOAD, OP_STORE, OP_R, OP_I: state_d = S_EXEC;
                            OP_BRANCH:                     state_d = S_BRANCH;
                            default:                       state_d = S_ERRO;
                        endcase
                    end
                end
                S_EXEC:   state_d = (opcode_q == OP_LOAD || opcode_q == OP_STORE) ? S_MEM : S_WB;
                S_MEM: begin
                    if (opcode_q == OP_LOAD) state_d = S_WB;
                    else                     fim_instr = 1'b1;
                end
                S_WB:     fim_instr = 1'b1;
                S_BRANCH: fim_instr = 1'b1;
                S_ERRO:   state_d = S_ERRO;
                S_HALT:   state_d = S_HALT;
                default:  state_d = S_ERRO;
            endcase

            if (fim_instr) begin
                pc_d    = pc_next;
                state_d = (pc_next >= PC_W'(N_INSTR)) ? S_HALT : S_FETCH;
            end
        end
    end

    // Strobes are decoded from the upcoming state so the registered copy is Moore-aligned.
    always_comb begin
        alu_src_d   = (state_d == S_EXEC) &&
                      (opcode_d == OP_LOAD || opcode_d == OP_STORE || opcode_d == OP_I);
        mem_read_d  = (state_d == S_MEM) && (opcode_d == OP_LOAD);
        mem_write_d = (state_d == S_MEM) && (opcode_d == OP_STORE);
        reg_write_d = (state_d == S_WB) &&
                      (opcode_d == OP_LOAD || opcode_d == OP_R || opcode_d == OP_I);
        halted_d    = (state_d == S_HALT) || (state_d == S_ERRO);
        erro_d      = (state_d == S_ERRO);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            pc_q      <= PC_W'(PC_INICIO);
            opcode_q  <= '0;
            funct3_q  <= '0;
            imm_q     <= '0;
            reg_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            alu_src   <= 1'b0;
            halted    <= 1'b0;
            erro      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            funct3_q  <= funct3_d;
            imm_q     <= imm_d;
            reg_write <= reg_write_d;
            mem_read  <= mem_read_d;
            mem_write <= mem_write_d;
            alu_src   <= alu_src_d;
            halted    <= halted_d;
            erro      <= erro_d;
        end
    end

    assign estado = state_q;
    assign pc     = pc_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: walks load/store/R/branch/halt/error
// sequences and checks state codes, pc and strobes against hand-computed values.
module tb_controle_multiciclo;

    logic        clk;
    logic        rst;
    logic        executar;
    logic [31:0] instrucao;
    logic        zero;
    logic [3:0]  estado;
    logic [31:0] pc;
    logic        reg_write, mem_read, mem_write, alu_src, halted, erro;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] I_LOAD   = 32'h0000A003;
    localparam logic [31:0] I_STORE  = 32'h0021A223;
    localparam logic [31:0] I_RTYPE  = 32'h405282B3;
    localparam logic [31:0] I_BEQ8   = 32'h00000463;
    localparam logic [31:0] I_BEQ24  = 32'h00000C63;
    localparam logic [31:0] I_BNE8   = 32'h00001463;
    localparam logic [31:0] I_BEQM8  = 32'hFE000CE3;
    localparam logic [31:0] I_ILLEG  = 32'h0000007F;

    controle_multiciclo dut (
        .clk       (clk),
        .rst       (rst),
        .executar  (executar),
        .instrucao (instrucao),
        .zero      (zero),
        .estado    (estado),
        .pc        (pc),
        .reg_write (reg_write),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .alu_src   (alu_src),
        .halted    (halted),
        .erro      (erro)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step_st(input string tag, input logic [3:0] exp);
        @(posedge clk);
        #1;
        chk(tag, 32'(estado), 32'(exp));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Branch instruction from FETCH back to FETCH, then pc check.
    task automatic run_branch(input string tag, input logic [31:0] w, input logic z,
                              input logic [31:0] exp_pc);
        instrucao = w;
        zero      = z;
        step_st({tag, "_dec"}, 4'h1);
        step_st({tag, "_br"}, 4'h5);
        step_st({tag, "_fetch"}, 4'h0);
        chk({tag, "_pc"}, pc, exp_pc);
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b0;
        executar  = 1'b1;
        instrucao = 32'h0;
        zero      = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_estado", 32'(estado), 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_outs", 32'({reg_write, mem_read, mem_write, alu_src, halted, erro}), 32'h0);
        rst = 1'b1;

        // load
        instrucao = I_LOAD;
        step_st("ld_dec", 4'h1);
        step_st("ld_exec", 4'h2);
        chk("ld_alu_src", 32'(alu_src), 32'h1);
        step_st("ld_mem", 4'h3);
        chk("ld_mem_read", 32'(mem_read), 32'h1);
        chk("ld_no_regw_mem", 32'(reg_write), 32'h0);
        step_st("ld_wb", 4'h4);
        chk("ld_reg_write", 32'(reg_write), 32'h1);
        chk("ld_no_mrd_wb", 32'(mem_read), 32'h0);
        chk("ld_pc_in_wb", pc, 32'h0);
        step_st("ld_fetch", 4'h0);
        chk("ld_pc", pc, 32'h1);
        chk("ld_regw_off", 32'(reg_write), 32'h0);

        // store
        instrucao = I_STORE;
        step_st("st_dec", 4'h1);
        step_st("st_exec", 4'h2);
        step_st("st_mem", 4'h3);
        chk("st_mem_write", 32'(mem_write), 32'h1);
        step_st("st_fetch", 4'h0);
        chk("st_pc", pc, 32'h2);
        chk("st_mw_off", 32'(mem_write), 32'h0);

        // R-type
        instrucao = I_RTYPE;
        step_st("r_dec", 4'h1);
        step_st("r_exec", 4'h2);
        chk("r_alu_src", 32'(alu_src), 32'h0);
        step_st("r_wb", 4'h4);
        chk("r_reg_write", 32'(reg_write), 32'h1);
        step_st("r_fetch", 4'h0);
        chk("r_pc", pc, 32'h3);

        // branches, then WB exit at pc=8 runs past N_INSTR
        do_reset();
        run_branch("beq24_t", I_BEQ24, 1'b1, 32'd6);
        run_branch("beq8_t", I_BEQ8, 1'b1, 32'd8);
        instrucao = I_RTYPE;
        step_st("r8_dec", 4'h1);
        step_st("r8_exec", 4'h2);
        step_st("r8_wb", 4'h4);
        step_st("r8_halt", 4'hF);
        chk("r8_pc", pc, 32'd9);
        chk("r8_halted", 32'(halted), 32'h1);
        chk("r8_erro", 32'(erro), 32'h0);

        // asynchronous reset out of HALT, no clock edge needed
        rst = 1'b0;
        #1;
        chk("async_estado", 32'(estado), 32'h0);
        chk("async_pc", pc, 32'h0);
        chk("async_halted", 32'(halted), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        run_branch("beq24_b", I_BEQ24, 1'b1, 32'd6);
        run_branch("beq8_nt", I_BEQ8, 1'b0, 32'd7);
        run_branch("bne_nt", I_BNE8, 1'b1, 32'd8);
        run_branch("beqm8_t", I_BEQM8, 1'b1, 32'd6);
        run_branch("bne_t", I_BNE8, 1'b0, 32'd8);

        // all-zero word halts; state and pc stay put
        instrucao = 32'h0;
        step_st("z_dec", 4'h1);
        step_st("z_halt", 4'hF);
        chk("z_halted", 32'(halted), 32'h1);
        chk("z_erro", 32'(erro), 32'h0);
        for (int i = 0; i < 3; i++) step_st("z_hold", 4'hF);
        chk("z_pc", pc, 32'd8);

        // illegal opcode
        do_reset();
        instrucao = I_ILLEG;
        step_st("il_dec", 4'h1);
        step_st("il_erro", 4'hE);
        chk("il_erro_flag", 32'(erro), 32'h1);
        chk("il_halted", 32'(halted), 32'h1);
        for (int i = 0; i < 2; i++) step_st("il_hold", 4'hE);

        // executar low for three edges while in EXEC
        do_reset();
        instrucao = I_LOAD;
        step_st("fz_dec", 4'h1);
        step_st("fz_exec", 4'h2);
        executar = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_st("fz_hold", 4'h2);
            chk("fz_alu_src", 32'(alu_src), 32'h1);
        end
        chk("fz_pc", pc, 32'h0);
        executar = 1'b1;
        step_st("fz_mem", 4'h3);
        step_st("fz_wb", 4'h4);
        step_st("fz_fetch", 4'h0);
        chk("fz_pc_after", pc, 32'h1);

        // reset during MEM of a store
        instrucao = I_STORE;
        step_st("rm_dec", 4'h1);
        step_st("rm_exec", 4'h2);
        step_st("rm_mem", 4'h3);
        chk("rm_mw_before", 32'(mem_write), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("rm_mw_drop", 32'(mem_write), 32'h0);
        chk("rm_estado", 32'(estado), 32'h0);
        chk("rm_pc", pc, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        instrucao = I_RTYPE;
        step_st("rs_dec", 4'h1);
        step_st("rs_exec", 4'h2);
        step_st("rs_wb", 4'h4);
        step_st("rs_fetch", 4'h0);
        chk("rs_pc", pc, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
